adder_err_monitor: RTL and testbench
====================================

# adder_err_monitor

Pipelined error-measurement stage placed directly downstream of the 16-bit approximate adders (LOA/GDA family) in the approximate-adder evaluation flow. Each cycle it can take one operand pair plus the approximate sum the adder produced for it, computes the exact sum internally, and accumulates error statistics over a programmable window of samples: sample count, erroneous-sample count, maximum error distance and summed error distance. A small FSM frames the window so that software or a testbench reads stable results after a one-cycle `done` pulse.

## Interface
- `W`, 16, operand width; approximate and exact sums are W+1 bits.
- `CNT_W`, 24, width of window length, sample counter and error counter.
- `SUM_W`, 40, width of the summed-error-distance accumulator.

- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to open a new window.
- `win_len`  in  CNT_W  number of samples in the window; sampled when `start` is accepted.
- `in_valid`  in  1  qualifies `in1`, `in2`, `approx` this cycle.
- `in1`, `in2`  in  W  operands that were presented to the adder.
- `approx`  in  W+1  adder result for `in1`, `in2`.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse; results valid and stable from this cycle until the next accepted `start`.
- `sample_cnt`  out  CNT_W  accumulated samples.
- `err_cnt`  out  CNT_W  samples with error distance ≠ 0.
- `max_ed`  out  W+1  largest error distance seen.
- `sum_ed`  out  SUM_W  sum of error distances, saturating.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE. All outputs reset to 0.
- IDLE: `start`=1 latches `win_len`, clears all accumulators and the accept counter. Next state is RUN, or DONE if `win_len`=0 (results remain all zero).
- RUN: a sample is accepted when `in_valid`=1 and accept count < latched `win_len`. When the accepted sample is number `win_len`, the next state is DRAIN. Gaps in `in_valid` are allowed and hold the state.
- Stage 1, on the accept edge: register `exact = in1 + in2` (W+1 bits, no overflow), register `approx`, set stage-1 valid.
- Stage 2, when stage-1 valid: `ed = |exact − approx|` in W+1 bits, unsigned, with either sign of difference. On this edge:
  - `sample_cnt` += 1.
  - `err_cnt` += (ed≠0).
  - `max_ed` = ed if ed > `max_ed`.
  - `sum_ed` += ed, saturating at all-ones.
- `sample_cnt` and `err_cnt` cannot overflow because they are bounded by `win_len`.
- DRAIN: lasts exactly one cycle, during which the last sample is accumulated. Next state is DONE.
- DONE: `done`=1 for one cycle, next state is IDLE.
- `start` in RUN, DRAIN or DONE is ignored. Inputs in IDLE and DONE are ignored.
- `rst_n` low at any point, including mid-window, returns to IDLE immediately, zeroes outputs and discards pipeline contents.

## Timing
- Latency: a sample accepted in cycle k is reflected in the outputs from cycle k+2.
- `start` in cycle t puts the block in RUN at t+1. The earliest accept is in cycle t+1.
- Last accept in cycle k: DRAIN in k+1, DONE with `done`=1 in k+2, IDLE in k+3.
- `busy` is high from t+1 through k+1.
- With `win_len`=0: `done` is high in t+1.
- Back-to-back windows: `start` in the IDLE cycle after DONE is accepted.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Test plan
- Exact-adder check: `win_len`=4, four samples with `approx`=`in1`+`in2` (e.g. 0x1234+0x0FFF → 0x02233). Required at `done`: `sample_cnt`=4, `err_cnt`=0, `max_ed`=0, `sum_ed`=0.
- Error signs: `win_len`=3 with these samples:
  - `in1`=0x000F, `in2`=0x0001, `approx`=0x0000F (ed 1).
  - `in1`=0x0010, `in2`=0x0000, `approx`=0x00020 (ed 0x10).
  - `in1`=0xFFFF, `in2`=0x0001, `approx`=0x10000 (ed 0).
  - Required: `err_cnt`=2, `max_ed`=0x10, `sum_ed`=0x11.
- Gaps and ignored start: `win_len`=2, `in_valid` pattern 1,0,0,1, with `start` pulsed during RUN. Required: the window is not restarted and `done` is exactly 2 cycles after the second accept.
- Saturation: `SUM_W`=8, `win_len`=3, each sample ed=0x80. Required: `sum_ed`=0xFF, `max_ed`=0x80.
- `win_len`=0: `start` → `done` the next cycle with all results 0, and `busy` never high.
- Reset mid-window: assert `rst_n`=0 after 2 of 5 samples. Required: all outputs 0 and state IDLE. A new `start` then runs a clean window.

Source files
------------

// File: rtl/adder_err_monitor.sv
// Error-measurement stage for 16-bit approximate adders.
// Accumulates sample count, error count, maximum and summed error distance
// over a window of accepted samples; results are stable from the `done` pulse
// until the next accepted start.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; results from the last window held
// S_RUN   | accepting samples until win_len have been taken
// S_DRAIN | one cycle for the last sample to reach the accumulators
// S_DONE  | done pulse; results final
module adder_err_monitor #(
  parameter int W     = 16,
  parameter int CNT_W = 24,
  parameter int SUM_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  input  logic             in_valid,
  input  logic [W-1:0]     in1,
  input  logic [W-1:0]     in2,
  input  logic [W:0]       approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [W:0]       max_ed,
  output logic [SUM_W-1:0] sum_ed
);

  // Sum is formed one bit wider than the larger operand so saturation can be
  // detected even when the accumulator is narrower than an error distance.
  localparam int                 ACC_W   = ((SUM_W > W + 1) ? SUM_W : (W + 1)) + 1;
  localparam logic [SUM_W-1:0]   SUM_ALL = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] win_len_q, win_len_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             s1_valid_q, s1_valid_d;
  logic [W:0]       exact_q, exact_d;
  logic [W:0]       approx_q, approx_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [W:0]       max_ed_q, max_ed_d;
  logic [SUM_W-1:0] sum_ed_q, sum_ed_d;

  logic             accept;
  logic             clear;
  logic [W:0]       ed;
  logic [ACC_W-1:0] sum_ext;

  // State, window bookkeeping, pipeline and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      win_len_q    <= '0;
      acc_cnt_q    <= '0;
      s1_valid_q   <= 1'b0;
      exact_q      <= '0;
      approx_q     <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      max_ed_q     <= '0;
      sum_ed_q     <= '0;
    end else begin
      state_q      <= state_d;
      win_len_q    <= win_len_d;
      acc_cnt_q    <= acc_cnt_d;
      s1_valid_q   <= s1_valid_d;
      exact_q      <= exact_d;
      approx_q     <= approx_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      max_ed_q     <= max_ed_d;
      sum_ed_q     <= sum_ed_d;
    end
  end

  // Window framing: start handling, sample acceptance and state sequencing.
  always_comb begin
    state_d   = state_q;
    win_len_d = win_len_q;
    acc_cnt_d = acc_cnt_q;
    accept    = 1'b0;
    clear     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          win_len_d = win_len;
          acc_cnt_d = '0;
          clear     = 1'b1;
          state_d   = (win_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (in_valid && (acc_cnt_q < win_len_q)) begin
          accept    = 1'b1;
          acc_cnt_d = acc_cnt_q + CNT_ONE;
          if ((acc_cnt_q + CNT_ONE) == win_len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage 1: capture exact and approximate sums of an accepted sample.
  always_comb begin
    s1_valid_d = accept;
    exact_d    = exact_q;
    approx_d   = approx_q;
    if (accept) begin
      exact_d  = {1'b0, in1} + {1'b0, in2};
      approx_d = approx;
    end
  end

  // Stage 2: error distance and statistics update (saturating sum).
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    max_ed_d     = max_ed_q;
    sum_ed_d     = sum_ed_q;
    ed           = (exact_q >= approx_q) ? (exact_q - approx_q) : (approx_q - exact_q);
    sum_ext      = ACC_W'(sum_ed_q) + ACC_W'(ed);
    if (clear) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      max_ed_d     = '0;
      sum_ed_d     = '0;
    end else if (s1_valid_q) begin
      sample_cnt_d = sample_cnt_q + CNT_ONE;
      err_cnt_d    = err_cnt_q + CNT_W'(ed != '0);
      if (ed > max_ed_q) max_ed_d = ed;
      sum_ed_d     = (sum_ext > ACC_W'(SUM_ALL)) ? SUM_ALL : sum_ext[SUM_W-1:0];
    end
  end

  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign max_ed     = max_ed_q;
  assign sum_ed     = sum_ed_q;

endmodule

// File: tb/tb_adder_err_monitor.sv
// Bench for adder_err_monitor: a wide-accumulator instance and an 8-bit
// accumulator instance share all stimulus; a behavioural model is compared
// every cycle, and directed windows carry hand-computed result expectations.
module tb_adder_err_monitor;

  localparam int W     = 16;
  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] win_len = '0;
  logic             in_valid = 1'b0;
  logic [W-1:0]     in1 = '0;
  logic [W-1:0]     in2 = '0;
  logic [W:0]       approx = '0;

  logic             busy, done, busy_s, done_s;
  logic [CNT_W-1:0] sample_cnt, err_cnt, sample_cnt_s, err_cnt_s;
  logic [W:0]       max_ed, max_ed_s;
  logic [39:0]      sum_ed;
  logic [7:0]       sum_ed_s;

  int checks = 0;
  int errors = 0;

  adder_err_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
    .in_valid(in_valid), .in1(in1), .in2(in2), .approx(approx),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .max_ed(max_ed), .sum_ed(sum_ed)
  );

  adder_err_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
    .in_valid(in_valid), .in1(in1), .in2(in2), .approx(approx),
    .busy(busy_s), .done(done_s), .sample_cnt(sample_cnt_s), .err_cnt(err_cnt_s),
    .max_ed(max_ed_s), .sum_ed(sum_ed_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 collecting samples, 2 last-sample drain, 3 results final
  int     m_mode = 0;
  longint m_win = 0, m_taken = 0;
  longint m_cnt = 0, m_err = 0, m_max = 0, m_sum_w = 0, m_sum_n = 0;
  bit     m_pend = 0;
  longint m_pend_ed = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_win = 0; m_taken = 0; m_pend = 0; m_pend_ed = 0;
      m_cnt = 0; m_err = 0; m_max = 0; m_sum_w = 0; m_sum_n = 0;
    end else begin
      // A sample accepted last cycle lands in the statistics on this edge.
      if (m_pend) begin
        m_cnt++;
        if (m_pend_ed != 0) m_err++;
        if (m_pend_ed > m_max) m_max = m_pend_ed;
        m_sum_w = m_sum_w + m_pend_ed;
        if (m_sum_w > 64'hFF_FFFF_FFFF) m_sum_w = 64'hFF_FFFF_FFFF;
        m_sum_n = m_sum_n + m_pend_ed;
        if (m_sum_n > 255) m_sum_n = 255;
        m_pend = 0;
      end
      case (m_mode)
        0: if (start) begin
          m_win = longint'(win_len); m_taken = 0;
          m_cnt = 0; m_err = 0; m_max = 0; m_sum_w = 0; m_sum_n = 0;
          m_mode = (m_win == 0) ? 3 : 1;
        end
        1: if (in_valid && m_taken < m_win) begin
          longint d;
          d = longint'(in1) + longint'(in2) - longint'(approx);
          if (d < 0) d = -d;
          m_pend = 1; m_pend_ed = d;
          m_taken++;
          if (m_taken == m_win) m_mode = 2;
        end
        2: m_mode = 3;
        default: m_mode = 0;
      endcase
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk);
    chk("busy",         busy,         longint'(m_mode == 1 || m_mode == 2));
    chk("done",         done,         longint'(m_mode == 3));
    chk("sample_cnt",   sample_cnt,   m_cnt);
    chk("err_cnt",      err_cnt,      m_err);
    chk("max_ed",       max_ed,       m_max);
    chk("sum_ed",       sum_ed,       m_sum_w);
    chk("busy_s",       busy_s,       longint'(m_mode == 1 || m_mode == 2));
    chk("done_s",       done_s,       longint'(m_mode == 3));
    chk("sample_cnt_s", sample_cnt_s, m_cnt);
    chk("max_ed_s",     max_ed_s,     m_max);
    chk("sum_ed_s",     sum_ed_s,     m_sum_n);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    start = 1'b1; win_len = CNT_W'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] ap);
    in_valid = 1'b1; in1 = a; in2 = b; approx = ap;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int n = 0;
    while (!done && n < max_cyc) begin
      tick();
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, max_cyc);
    end
  endtask

  task automatic chk_res(input string name, input longint c, input longint e,
                         input longint mx, input longint s);
    chk({name, "_sample_cnt"}, sample_cnt, c);
    chk({name, "_err_cnt"},    err_cnt,    e);
    chk({name, "_max_ed"},     max_ed,     mx);
    chk({name, "_sum_ed"},     sum_ed,     s);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk_res("rst", 0, 0, 0, 0);
    tick();

    // Exact adder: no errors.
    do_start(4);
    chk("exact_busy", busy, 1);
    send(16'h1234, 16'h0FFF, 17'h02233);
    send(16'hFFFF, 16'hFFFF, 17'h1FFFE);
    send(16'h0000, 16'h0000, 17'h00000);
    send(16'h8000, 16'h8000, 17'h10000);
    wait_done("exact", 4);
    chk_res("exact", 4, 0, 0, 0);
    tick();

    // Error of both signs; started in the IDLE cycle right after DONE.
    do_start(3);
    send(16'h000F, 16'h0001, 17'h0000F);
    send(16'h0010, 16'h0000, 17'h00020);
    send(16'hFFFF, 16'h0001, 17'h10000);
    wait_done("signs", 4);
    chk_res("signs", 3, 2, 'h10, 'h11);
    tick();

    // Gaps in in_valid and a start pulse during RUN.
    do_start(2);
    send(16'h0100, 16'h0100, 17'h00200);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    send(16'h0005, 16'h0003, 17'h00006);
    chk("gap_drain_busy", busy, 1);
    chk("gap_drain_done", done, 0);
    tick();
    chk("gap_done_at_k2", done, 1);
    chk_res("gap", 2, 1, 2, 2);
    start = 1'b1; tick(); start = 1'b0;
    chk("done_start_ignored_busy", busy, 0);
    chk("done_start_ignored_cnt", sample_cnt, 2);
    tick();

    // Saturation of the 8-bit accumulator.
    do_start(3);
    send(16'h0080, 16'h0000, 17'h00000);
    send(16'h0040, 16'h0040, 17'h00100);
    send(16'h1000, 16'h0000, 17'h01080);
    wait_done("sat", 4);
    chk("sat_sum_s", sum_ed_s, 'hFF);
    chk("sat_max_s", max_ed_s, 'h80);
    chk_res("sat_wide", 3, 3, 'h80, 'h180);
    tick();

    // Zero-length window.
    do_start(0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk_res("zero", 0, 0, 0, 0);
    tick();
    chk("zero_after_done", done, 0);

    // Reset in the middle of a window.
    do_start(5);
    send(16'h0001, 16'h0001, 17'h00000);
    send(16'h0002, 16'h0002, 17'h00000);
    tick();
    chk("pre_rst_cnt", sample_cnt, 2);
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk_res("midrst", 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start(2);
    send(16'h0001, 16'h0001, 17'h00003);
    send(16'h0002, 16'h0002, 17'h00004);
    wait_done("post_rst", 4);
    chk_res("post_rst", 2, 1, 1, 1);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
